load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store per instruction from the CPU datapath and issues it to data memory over a req/gnt/rvalid handshake.
- Stalls the pipeline until the memory transaction completes.
- Owns byte-lane formatting for stores and alignment plus sign/zero extension for loads, so memory sees only word-aligned addresses and byte enables.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/response bus; master = load/store unit, slave = memory.
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: store replication and byte enables, misalign
// detection, and load shift with sign/zero extension.
module lsu_align import lsu_pkg::*; (
  input  size_t       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] fmt_wdata,
  output logic [3:0]  fmt_be,
  output logic        misaligned,
  input  size_t       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata_raw,
  output logic [31:0] ld_data
);
  logic [31:0] shifted;

  always_comb begin
    fmt_wdata  = st_wdata;
    fmt_be     = 4'b0000;
    misaligned = 1'b0;
    case (st_size)
      SZ_B: begin
        fmt_wdata = {4{st_wdata[7:0]}};
        fmt_be    = 4'b0001 << st_off;
      end
      SZ_H: begin
        fmt_wdata  = {2{st_wdata[15:0]}};
        fmt_be     = 4'b0011 << st_off;
        misaligned = st_off[0];
      end
      SZ_W: begin
        fmt_be     = BE_WORD;
        misaligned = (st_off != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign shifted = rdata_raw >> {ld_off, 3'b000};

  // Word accesses are always aligned, so shifted equals the raw word there.
  always_comb begin
    ld_data = shifted;
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per instruction, stalls until done.
// Optional WAIT-state timeout abort enabled by macro LSU_TIMEOUT_EN.
module load_store_unit import lsu_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic                  ls_unsigned,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_stall,
  output logic                  ls_done,
  output logic                  ls_err,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  lsu_if.master                 mem
);
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("load_store_unit: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
  end

  lsu_state_t            state_q, state_d;
  logic                  we_q, uns_q, err_q;
  size_t                 size_q;
  logic [1:0]            off_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [31:0] fmt_wdata, ld_data;
  logic [3:0]  fmt_be;
  logic        misaligned;
  logic        accept, finish;

  lsu_align u_align (
    .st_size     (size_t'(ls_size)),
    .st_off      (ls_addr[1:0]),
    .st_wdata    (ls_wdata),
    .fmt_wdata   (fmt_wdata),
    .fmt_be      (fmt_be),
    .misaligned  (misaligned),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata_raw   (mem.rdata),
    .ld_data     (ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    ls_stall = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    expire   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        ls_stall = ls_valid;
        if (ls_valid) begin
          accept  = 1'b1;
          state_d = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        ls_stall = 1'b1;
        if (mem.gnt) begin
          if (mem.rvalid) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        ls_stall = 1'b1;
        if (mem.rvalid) begin
          finish  = 1'b1;
          state_d = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= ls_we;
        size_q  <= size_t'(ls_size);
        uns_q   <= ls_unsigned;
        off_q   <= ls_addr[1:0];
        be_q    <= fmt_be;
        wdata_q <= fmt_wdata;
        addr_q  <= {ls_addr[ADDR_WIDTH-1:2], 2'b00};
        err_q   <= misaligned;
        rdata_q <= '0;
      end
      if (finish) begin
        err_q   <= 1'b0;
        rdata_q <= we_q ? '0 : ld_data;
      end
`ifdef LSU_TIMEOUT_EN
      if (expire) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
`endif
    end
  end

  // Bus fields read as zero outside REQ so memory never sees stale requests.
  assign mem.req   = (state_q == REQ);
  assign mem.we    = mem.req & we_q;
  assign mem.be    = mem.req ? be_q    : 4'b0000;
  assign mem.addr  = mem.req ? addr_q  : '0;
  assign mem.wdata = mem.req ? wdata_q : '0;

  assign ls_done  = (state_q == DONE);
  assign ls_err   = ls_done & err_q;
  assign ls_rdata = ls_done ? rdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit plus reset and timeout sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_we, ls_unsigned;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_stall, ls_done, ls_err;
  logic [31:0] ls_rdata;

  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem(mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, mrdata;
    int          gd, rd;
    bit          stray;
    bit          acc;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata;
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t v[12];
  vec_t vx;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] mrdata, int gd, int rd,
                              bit stray, bit acc, logic [3:0] be, logic [31:0] maddr,
                              logic [31:0] mwdata, logic err, logic [31:0] rdata, int dc);
    vec_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.mrdata = mrdata; r.gd = gd; r.rd = rd; r.stray = stray; r.acc = acc;
    r.be = be; r.maddr = maddr; r.mwdata = mwdata; r.err = err; r.rdata = rdata;
    r.done_cyc = dc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    ls_valid = 1'b1; ls_we = x.we; ls_size = x.size; ls_unsigned = x.uns;
    ls_addr = x.addr; ls_wdata = x.wdata;
  endtask

  task automatic clear_ls();
    ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
    ls_addr = '0; ls_wdata = '0;
  endtask

  // Entered 2 time units after the accepting edge's predecessor, inputs already applied.
  task automatic run_vec(input int i, input vec_t x, input bit has_next, input vec_t nx);
    int req_cnt = 0, gnt_cyc = -1, done_at = -1, stall_bad = 0, stab_bad = 0;
    bit done_seen = 0;
    logic [3:0] be0 = '0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic we0 = 1'b0;
    mem_bus.rdata = x.mrdata;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      #1;
      if (cyc == 0) chk($sformatf("v%0d_idle_req", i), {31'd0, mem_bus.req}, 32'd0);
      mem_bus.gnt = 1'b0;
      mem_bus.rvalid = 1'b0;
      if (ls_done) begin
        done_seen = 1;
        done_at = cyc;
        chk($sformatf("v%0d_err", i), {31'd0, ls_err}, {31'd0, x.err});
        chk($sformatf("v%0d_rdata", i), ls_rdata, x.rdata);
        chk($sformatf("v%0d_stall_done", i), {31'd0, ls_stall}, 32'd0);
        if (has_next) apply(nx); else clear_ls();
      end else begin
        if (ls_stall !== 1'b1) stall_bad++;
        if (mem_bus.req) begin
          if (req_cnt == 0) begin
            be0 = mem_bus.be; addr0 = mem_bus.addr; wdata0 = mem_bus.wdata; we0 = mem_bus.we;
          end else if (mem_bus.be !== be0 || mem_bus.addr !== addr0 ||
                       mem_bus.wdata !== wdata0 || mem_bus.we !== we0) begin
            stab_bad++;
          end
          if (req_cnt == x.gd) begin
            mem_bus.gnt = 1'b1;
            gnt_cyc = cyc;
            mem_bus.rvalid = (x.rd == 0);
          end else begin
            mem_bus.rvalid = x.stray;
          end
          req_cnt++;
        end else if (gnt_cyc >= 0 && cyc - gnt_cyc == x.rd) begin
          mem_bus.rvalid = 1'b1;
        end
      end
      @(posedge clk);
      #2;
    end
    chk($sformatf("v%0d_done_cycle", i), done_at, x.done_cyc);
    chk($sformatf("v%0d_req_cycles", i), req_cnt, x.acc ? x.gd + 1 : 0);
    chk($sformatf("v%0d_stall_bad", i), stall_bad, 0);
    if (x.acc) begin
      chk($sformatf("v%0d_req_stable", i), stab_bad, 0);
      chk($sformatf("v%0d_be", i), {28'd0, be0}, {28'd0, x.be});
      chk($sformatf("v%0d_addr", i), addr0, x.maddr);
      chk($sformatf("v%0d_wdata", i), wdata0, x.mwdata);
      chk($sformatf("v%0d_we", i), {31'd0, we0}, {31'd0, x.we});
    end
  endtask

  initial begin
    //        we    size   uns   addr   wdata        mrdata       gd rd st acc be       maddr  mwdata       err   rdata        dc
    v[0]  = mk(1'b1, 2'b10, 1'b0, 'h100, 'hDEADBEEF, 'h0,        0, 0, 0, 1, 4'b1111, 'h100, 'hDEADBEEF, 1'b0, 'h0,        2);
    v[1]  = mk(1'b0, 2'b00, 1'b0, 'h203, 'h0,        'h80112233, 1, 1, 0, 1, 4'b1000, 'h200, 'h0,        1'b0, 'hFFFFFF80, 4);
    v[2]  = mk(1'b0, 2'b00, 1'b1, 'h203, 'h0,        'h80112233, 0, 0, 0, 1, 4'b1000, 'h200, 'h0,        1'b0, 'h00000080, 2);
    v[3]  = mk(1'b1, 2'b01, 1'b0, 'h42,  'h1234ABCD, 'h0,        3, 2, 0, 1, 4'b1100, 'h40,  'hABCDABCD, 1'b0, 'h0,        7);
    v[4]  = mk(1'b0, 2'b10, 1'b0, 'h06,  'h0,        'h0,        0, 0, 0, 0, 4'b0000, 'h0,   'h0,        1'b1, 'h0,        1);
    v[5]  = mk(1'b0, 2'b01, 1'b0, 'h02,  'h0,        'h80017FFF, 0, 1, 0, 1, 4'b1100, 'h0,   'h0,        1'b0, 'hFFFF8001, 3);
    v[6]  = mk(1'b0, 2'b01, 1'b1, 'h0,   'h0,        'h1234F00D, 2, 0, 1, 1, 4'b0011, 'h0,   'h0,        1'b0, 'h0000F00D, 4);
    v[7]  = mk(1'b1, 2'b00, 1'b0, 'h301, 'hFFFFFF5A, 'h0,        0, 0, 0, 1, 4'b0010, 'h300, 'h5A5A5A5A, 1'b0, 'h0,        2);
    v[8]  = mk(1'b0, 2'b11, 1'b0, 'h0,   'h0,        'h0,        0, 0, 0, 0, 4'b0000, 'h0,   'h0,        1'b1, 'h0,        1);
    v[9]  = mk(1'b1, 2'b01, 1'b0, 'h1,   'h5555,     'h0,        0, 0, 0, 0, 4'b0000, 'h0,   'h0,        1'b1, 'h0,        1);
    v[10] = mk(1'b0, 2'b10, 1'b0, 'h10,  'h0,        'hCAFEF00D, 1, 0, 0, 1, 4'b1111, 'h10,  'h0,        1'b0, 'hCAFEF00D, 3);
    v[11] = mk(1'b0, 2'b00, 1'b0, 'h1,   'h0,        'h00007F00, 0, 0, 0, 1, 4'b0010, 'h0,   'h0,        1'b0, 'h0000007F, 2);

    rst = 1'b1;
    clear_ls();
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_bus.req}, 32'd0);
    chk("rst_stall", {31'd0, ls_stall}, 32'd0);
    chk("rst_done", {31'd0, ls_done}, 32'd0);
    chk("rst_rdata", ls_rdata, 32'd0);
    #1;
    rst = 1'b0;

    apply(v[0]);
    for (int i = 0; i < 12; i++) begin
      run_vec(i, v[i], i < 11, v[(i < 11) ? i + 1 : i]);
    end
    #1;
    chk("last_done_once", {31'd0, ls_done}, 32'd0);
    chk("last_idle_stall", {31'd0, ls_stall}, 32'd0);

    // Reset while waiting for the response, then a normal load.
    vx = mk(1'b0, 2'b10, 1'b0, 'h20, 'h0, 'h0, 0, 0, 0, 1, 4'b1111, 'h20, 'h0, 1'b0, 'h0, 2);
    apply(vx);
    @(posedge clk); #3;
    chk("rw_in_req", {31'd0, mem_bus.req}, 32'd1);
    mem_bus.gnt = 1'b1;
    @(posedge clk); #3;
    mem_bus.gnt = 1'b0;
    chk("rw_in_wait_stall", {31'd0, ls_stall}, 32'd1);
    rst = 1'b1;
    clear_ls();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rw_req", {31'd0, mem_bus.req}, 32'd0);
    chk("rw_stall", {31'd0, ls_stall}, 32'd0);
    chk("rw_done", {31'd0, ls_done}, 32'd0);
    chk("rw_be", {28'd0, mem_bus.be}, 32'd0);
    chk("rw_addr", mem_bus.addr, 32'd0);
    vx = mk(1'b0, 2'b10, 1'b0, 'h24, 'h0, 'h11223344, 0, 0, 0, 1, 4'b1111, 'h24, 'h0, 1'b0, 'h11223344, 2);
    apply(vx);
    run_vec(20, vx, 0, vx);

`ifdef LSU_TIMEOUT_EN
    vx = mk(1'b0, 2'b10, 1'b0, 'h30, 'h0, 'h0, 0, 99, 0, 1, 4'b1111, 'h30, 'h0, 1'b1, 'h0, 6);
    apply(vx);
    run_vec(30, vx, 0, vx);
    mem_bus.rvalid = 1'b1;
    @(posedge clk); #2;
    mem_bus.rvalid = 1'b0;
    #1;
    chk("stray_rvalid_done", {31'd0, ls_done}, 32'd0);
    chk("stray_rvalid_req", {31'd0, mem_bus.req}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
